// File: rtl/md5_pkg.sv
// Shared MD5 datapath constants: word/rotate widths, word type and the
// per-round left-rotate distances used by the round controller.
package md5_pkg;

  localparam int WORD_W = 32;
  localparam int ROT_W  = 5;

  typedef logic [WORD_W-1:0] word_t;

  // Rotate distance for round i, consumed as shift_amount by left_rotate.
  localparam logic [ROT_W-1:0] S [64] = '{
    5'd7,  5'd12, 5'd17, 5'd22, 5'd7,  5'd12, 5'd17, 5'd22,
    5'd7,  5'd12, 5'd17, 5'd22, 5'd7,  5'd12, 5'd17, 5'd22,
    5'd5,  5'd9,  5'd14, 5'd20, 5'd5,  5'd9,  5'd14, 5'd20,
    5'd5,  5'd9,  5'd14, 5'd20, 5'd5,  5'd9,  5'd14, 5'd20,
    5'd4,  5'd11, 5'd16, 5'd23, 5'd4,  5'd11, 5'd16, 5'd23,
    5'd4,  5'd11, 5'd16, 5'd23, 5'd4,  5'd11, 5'd16, 5'd23,
    5'd6,  5'd10, 5'd15, 5'd21, 5'd6,  5'd10, 5'd15, 5'd21,
    5'd6,  5'd10, 5'd15, 5'd21, 5'd6,  5'd10, 5'd15, 5'd21
  };

endpackage

// File: rtl/rotl_stage.sv
// One level of the barrel rotator: rotate left by a fixed DIST when en is set,
// otherwise pass the word through unchanged.
module rotl_stage
  import md5_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] rotated;

  assign rotated = {din[WIDTH-1-DIST:0], din[WIDTH-1:WIDTH-DIST]};
  assign dout    = en ? rotated : din;

endmodule

// File: rtl/left_rotate.sv
// Registered left-rotate for the MD5 round: a log2(WIDTH)-level barrel network
// feeding a single output register with a valid flag.
module left_rotate
  import md5_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int SHIFT_W = ROT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHIFT_W-1:0] shift_amount,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid
);

  // Stage 0: combinational barrel network, level k rotates by 2^k.
  logic [WIDTH-1:0] stage_p0 [SHIFT_W+1];

  assign stage_p0[0] = in;

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    rotl_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .din  (stage_p0[k]),
      .en   (shift_amount[k]),
      .dout (stage_p0[k+1])
    );
  end

  // Stage 1: output register; data only loads on valid so idle cycles do not toggle it.
  logic [WIDTH-1:0] out_p1;
  logic             vld_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        out_p1 <= stage_p0[SHIFT_W];
      end
    end
  end

  assign out       = out_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_left_rotate.sv
// Directed and randomized bench for left_rotate, checked against a word-level
// rotate model built from a doubled word.
module tb_left_rotate;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] din;
  logic [4:0]  sh;
  logic [31:0] dout;
  logic        dvld;

  int total = 0;
  int bad   = 0;

  left_rotate #(
    .WIDTH   (32),
    .SHIFT_W (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in           (din),
    .shift_amount (sh),
    .out          (dout),
    .out_valid    (dvld)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x} << s;
    return d[63:32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s);
    in_valid = v;
    din      = d;
    sh       = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_out;
  logic        exp_vld;
  logic [31:0] rin;
  logic [4:0]  rsh;
  logic        rv;

  initial begin
    rst = 1'b0;
    drive(1'b1, 32'h12345678, 5'd4);
    tick();
    check("pre_reset_rotl4", dout, 32'h23456781);
    check("pre_reset_vld", {31'd0, dvld}, 32'd1);

    // asynchronous reset, mid-cycle, with valid all-ones on the input
    drive(1'b1, 32'hFFFFFFFF, 5'd3);
    #2 rst = 1'b1;
    #1;
    check("reset_async_out", dout, 32'h0);
    check("reset_async_vld", {31'd0, dvld}, 32'd0);
    tick();
    check("reset_hold1_out", dout, 32'h0);
    check("reset_hold1_vld", {31'd0, dvld}, 32'd0);
    tick();
    check("reset_hold2_out", dout, 32'h0);
    check("reset_hold2_vld", {31'd0, dvld}, 32'd0);
    rst = 1'b0;

    // basic rotates, identity and half-word swap
    drive(1'b1, 32'hF387551A, 5'd1);  tick(); check("rot1", dout, 32'hE70EAA35);
    drive(1'b1, 32'hF387551A, 5'd5);  tick(); check("rot5", dout, 32'h70EAA35E);
    drive(1'b1, 32'hF387551A, 5'd31); tick(); check("rot31", dout, 32'h79C3AA8D);
    drive(1'b1, 32'hF387551A, 5'd0);  tick(); check("rot0", dout, 32'hF387551A);
    drive(1'b1, 32'hF387551A, 5'd16); tick(); check("rot16", dout, 32'h551AF387);
    drive(1'b1, 32'hFFFFFFFF, 5'd13); tick(); check("ones_inv", dout, 32'hFFFFFFFF);
    drive(1'b1, 32'h00000000, 5'd27); tick(); check("zeros_inv", dout, 32'h00000000);

    // back-to-back pipeline, then idle inputs driven as X
    drive(1'b1, 32'hF387551A, 5'd1);  tick();
    check("pipe0_out", dout, 32'hE70EAA35); check("pipe0_vld", {31'd0, dvld}, 32'd1);
    drive(1'b1, 32'hF387551A, 5'd5);  tick();
    check("pipe1_out", dout, 32'h70EAA35E); check("pipe1_vld", {31'd0, dvld}, 32'd1);
    drive(1'b1, 32'hF387551A, 5'd31); tick();
    check("pipe2_out", dout, 32'h79C3AA8D); check("pipe2_vld", {31'd0, dvld}, 32'd1);
    drive(1'b0, 'x, 'x); tick();
    check("pipe_hold_out", dout, 32'h79C3AA8D); check("pipe_hold_vld", {31'd0, dvld}, 32'd0);
    tick();
    check("pipe_hold2_out", dout, 32'h79C3AA8D); check("pipe_hold2_vld", {31'd0, dvld}, 32'd0);

    // single-bit sweep
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 32'h00000001, 5'(k));
      tick();
      check($sformatf("sweep%0d", k), dout, 32'h1 << k);
    end
    drive(1'b1, 32'h80000000, 5'd1); tick(); check("msb_wrap", dout, 32'h00000001);

    // random scoreboard with a mid-stream reset
    exp_out = dout;
    exp_vld = dvld;
    for (int i = 0; i < 10000; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rin = $urandom;
      rsh = 5'($urandom_range(0, 31));
      if (rv) drive(1'b1, rin, rsh);
      else    drive(1'b0, 'x, 'x);
      if (i == 5000) begin
        drive(1'b1, rin, rsh);
        #2 rst = 1'b1;
        #1;
        check("rnd_reset_out", dout, 32'h0);
        check("rnd_reset_vld", {31'd0, dvld}, 32'd0);
        tick();
        check("rnd_reset_drop_out", dout, 32'h0);
        check("rnd_reset_drop_vld", {31'd0, dvld}, 32'd0);
        rst = 1'b0;
        exp_out = 32'h0;
        exp_vld = 1'b0;
        continue;
      end
      tick();
      exp_vld = rv;
      if (rv) exp_out = ref_rotl(rin, int'(rsh));
      check("rnd_vld", {31'd0, dvld}, {31'd0, exp_vld});
      check("rnd_out", dout, exp_out);
      if (rv) check("rnd_popcount", 32'($countones(dout)), 32'($countones(rin)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/left_rotate.md
Name: left_rotate

Overview:
- Registered 32-bit left-rotate (circular shift) unit for the MD5 round datapath, the `leftrotate(F, s[i])` step.
- Computes out = (in << shift_amount) | (in >> (WIDTH - shift_amount)). Bits shifted out of the MSB re-enter at the LSB.
- Uses a logarithmic barrel network of SHIFT_W stages, followed by one output register stage with a valid flag.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, at least 2.
- SHIFT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies in and shift_amount this cycle.
- in  input  WIDTH  word to rotate.
- shift_amount  input  SHIFT_W  left-rotate distance, 0..WIDTH-1.
- out  output  WIDTH  rotated word, registered.
- out_valid  output  1  out holds a result captured from a cycle with in_valid=1.

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - out = 0 and out_valid = 0 immediately.
  - Both are held while rst=1.
  - Deassertion is sampled synchronously; the first capture occurs on the first rising edge with rst=0.
- Datapath:
  - Purely combinational barrel network. Stage k rotates left by 2^k when shift_amount[k]=1, otherwise passes its input through.
  - Stages run k = 0..SHIFT_W-1. Composing the stages gives a rotate by shift_amount mod WIDTH.
- Latency: exactly 1 cycle.
  - On each rising edge with rst=0, out_valid <= in_valid.
  - If in_valid=1: out <= rotl(in, shift_amount).
  - If in_valid=0: out holds its previous value. No zeroing; this keeps output toggling low.
- Throughput: one result per cycle. No backpressure and no stall input. Back-to-back valid inputs produce back-to-back valid outputs.
- Boundary conditions:
  - shift_amount=0: out = in.
  - shift_amount=WIDTH-1: equivalent to rotate right by 1.
  - All-zeros and all-ones inputs are invariant under any shift.
  - Every shift_amount value is legal, and no out-of-range value exists.
- Rotation preserves the population count of the word: popcount(out) = popcount(in).
- No X propagation from idle inputs: when in_valid=0, in and shift_amount may be X without affecting out.
- Reset mid-stream: an in-flight result is discarded; out=0 and out_valid=0 until a new valid capture.

Decomposition:
- Shared package md5_pkg:
  - Constants WORD_W=32 and ROT_W=5.
  - Word typedef, logic [WORD_W-1:0].
  - MD5 per-round shift table S[0:63], consumed by the round controller that drives shift_amount.
- One sub-module is natural: rotl_stage.
  - Parameters WIDTH and DIST.
  - Ports: input word, enable bit, output word. Output is the input rotated by DIST when enabled, otherwise the input.
  - Instantiated SHIFT_W times via a generate loop.

Test Plan:
- Reset:
  - Assert rst with in=0xFFFFFFFF, in_valid=1.
  - Required: out=0x00000000 and out_valid=0 without a clock edge, and held across edges.
- Basic rotates, in=0xF387551A, one cycle after each capture:
  - shift_amount=1 -> out=0xE70EAA35.
  - shift_amount=5 -> out=0x70EAA35E.
  - shift_amount=31 -> out=0x79C3AA8D.
- Identity and half-word swap, in=0xF387551A:
  - shift_amount=0 -> out=0xF387551A.
  - shift_amount=16 -> out=0x551AF387.
- Pipelining:
  - Apply three back-to-back valid inputs (shift_amount 1, 5, 31), then in_valid=0.
  - Required: out_valid high for exactly 3 consecutive cycles, results in input order.
  - After that, out holds 0x79C3AA8D with out_valid=0.
- Single-bit sweep:
  - in=0x00000001, shift_amount=k for k=0..31.
  - Required: out=1<<k.
  - Then in=0x80000000, shift_amount=1 -> out=0x00000001.
- Random scoreboard:
  - 10k random (in, shift_amount) pairs with random in_valid.
  - Compare against a reference-model rotate; also check popcount(out)=popcount(in).
  - Assert rst mid-stream and check the in-flight result is dropped.
